// File: rtl/music_pkg.sv
// music_pkg: shared definitions for the music_player audio path.
//   MUSIC_SAMPLE_W      default signed sample width
//   MIX_SAT_MAX/MIN     saturation limits for the default sample width
//   mix_state_e         voice_mixer FSM states
package music_pkg;

  localparam int MUSIC_SAMPLE_W = 16;
  localparam int MIX_SAT_MAX    = (2 ** (MUSIC_SAMPLE_W - 1)) - 1;
  localparam int MIX_SAT_MIN    = -(2 ** (MUSIC_SAMPLE_W - 1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SUM,
    ST_EMIT
  } mix_state_e;

endpackage

// File: rtl/mix_saturator.sv
// mix_saturator: combinational masked sum of the held voice samples,
// arithmetic right shift by GAIN_SHIFT (floor), then saturation to the
// signed SAMPLE_W range.
//   hold_i    flattened held samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   mask_i    voices that contribute; masked-off voices add 0
//   sample_o  saturated, scaled sum
//   clip_o    high when saturation changed the value
module mix_saturator #(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_SHIFT = 2
) (
  input  logic [NUM_VOICES*SAMPLE_W-1:0] hold_i,
  input  logic [NUM_VOICES-1:0]          mask_i,
  output logic [SAMPLE_W-1:0]            sample_o,
  output logic                           clip_o
);

  localparam int ACC_W = SAMPLE_W + 2;
  localparam int MAX_I = (2 ** (SAMPLE_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-MAX_I - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic        [SAMPLE_W-1:0] voice_v;

  always_comb begin
    acc     = '0;
    voice_v = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_v = hold_i[i*SAMPLE_W +: SAMPLE_W];
      if (mask_i[i]) begin
        acc = acc + $signed({{(ACC_W-SAMPLE_W){voice_v[SAMPLE_W-1]}}, voice_v});
      end
    end
  end

  // >>> on a signed operand rounds toward minus infinity (-7 >>> 2 = -2).
  assign shifted = acc >>> GAIN_SHIFT;

  always_comb begin
    sample_o = shifted[SAMPLE_W-1:0];
    clip_o   = 1'b0;
    if (shifted > MAX_V) begin
      sample_o = MAX_V[SAMPLE_W-1:0];
      clip_o   = 1'b1;
    end else if (shifted < MIN_V) begin
      sample_o = MIN_V[SAMPLE_W-1:0];
      clip_o   = 1'b1;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: gathers one sample from each voice active at request time,
// then presents a scaled, saturated mix with a one-cycle mix_ready pulse.
// A COLLECT timeout keeps a stalled voice from starving the codec.
//   clk, reset_n          clock, async active-low reset
//   generate_next_sample  round request (honoured in IDLE only)
//   voice_active          per-voice busy flags, snapshotted at request
//   voice_sample          flattened voice samples
//   voice_ready           per-voice new-sample pulses
//   mix_sample            registered mix, held between rounds
//   mix_ready             one-cycle pulse per completed round
//   clip                  saturation flag, valid with mix_ready
//   missed_count          saturating count of timed-out rounds
//
// state   | meaning
// IDLE    | waiting for a request
// COLLECT | latching samples from expected voices, timer running
// SUM     | registering the saturated mix
// EMIT    | mix_ready (and clip) high for this one cycle
module voice_mixer
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = MUSIC_SAMPLE_W,
  parameter int GAIN_SHIFT = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           generate_next_sample,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  output logic [SAMPLE_W-1:0]            mix_sample,
  output logic                           mix_ready,
  output logic                           clip,
  output logic [7:0]                     missed_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  mix_state_e                    state_q;
  logic [NUM_VOICES-1:0]         expected_q;
  logic [NUM_VOICES-1:0]         got_q;
  logic [NUM_VOICES*SAMPLE_W-1:0] hold_q;
  logic [TW-1:0]                 timer_q;
  logic [SAMPLE_W-1:0]           mix_sample_q;
  logic                          mix_ready_q;
  logic                          clip_q;
  logic [7:0]                    missed_q;

  logic [NUM_VOICES-1:0]         load_mask;
  logic [SAMPLE_W-1:0]           sat_sample;
  logic                          sat_clip;

  // Voices whose sample is captured this cycle; non-expected voices never load.
  always_comb begin
    load_mask = '0;
    if (state_q == ST_IDLE && generate_next_sample) begin
      load_mask = voice_ready & voice_active;
    end else if (state_q == ST_COLLECT) begin
      load_mask = voice_ready & expected_q;
    end
  end

  mix_saturator #(
    .NUM_VOICES (NUM_VOICES),
    .SAMPLE_W   (SAMPLE_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_sat (
    .hold_i   (hold_q),
    .mask_i   (expected_q),
    .sample_o (sat_sample),
    .clip_o   (sat_clip)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      expected_q   <= '0;
      got_q        <= '0;
      hold_q       <= '0;
      timer_q      <= '0;
      mix_sample_q <= '0;
      mix_ready_q  <= 1'b0;
      clip_q       <= 1'b0;
      missed_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_mask[i]) begin
          hold_q[i*SAMPLE_W +: SAMPLE_W] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
        end
      end
      unique case (state_q)
        ST_IDLE: begin
          mix_ready_q <= 1'b0;
          clip_q      <= 1'b0;
          if (generate_next_sample) begin
            expected_q <= voice_active;
            got_q      <= load_mask;
            timer_q    <= '0;
            state_q    <= (voice_active == '0) ? ST_SUM : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          got_q <= got_q | load_mask;
          if ((got_q | load_mask) == expected_q) begin
            state_q <= ST_SUM;
          end else if (timer_q == TIMER_LAST) begin
            // Missing voices keep their previous hold value.
            state_q <= ST_SUM;
            if (missed_q != 8'hFF) missed_q <= missed_q + 8'd1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_SUM: begin
          mix_sample_q <= sat_sample;
          clip_q       <= sat_clip;
          mix_ready_q  <= 1'b1;
          state_q      <= ST_EMIT;
        end
        ST_EMIT: begin
          mix_ready_q <= 1'b0;
          clip_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mix_sample   = mix_sample_q;
  assign mix_ready    = mix_ready_q;
  assign clip         = clip_q;
  assign missed_count = missed_q;

endmodule
